// File: rtl/multicycle_step_sequencer_if.sv
// Fetch/step bus between the multicycle step sequencer (slave) and its memory/decoder side (master).
interface multicycle_step_sequencer_if #(
  parameter int CNT_W  = 3,
  parameter int OPID_W = 6
);
  logic [15:0]       Ins;
  logic              Ins_valid;
  logic [CNT_W-1:0]  Cnt;
  logic [4:0]        InsM;
  logic [1:0]        InsL;
  logic [OPID_W-1:0] OpID;
  logic              Buff_PC;
  logic              Halted;
  logic              IllegalOp;

  modport master (
    output Ins, Ins_valid,
    input  Cnt, InsM, InsL, OpID, Buff_PC, Halted, IllegalOp
  );

  modport slave (
    input  Ins, Ins_valid,
    output Cnt, InsM, InsL, OpID, Buff_PC, Halted, IllegalOp
  );
endinterface

// File: rtl/multicycle_step_sequencer.sv
// Step counter + instruction register for the multicycle RISC controller.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (illegal encodings stop the core in a TRAP state).
module multicycle_step_sequencer #(
  parameter int CNT_W  = 3,
  parameter int OPID_W = 6
) (
  input  logic                          clk,
  input  logic                          Rst_n,
  multicycle_step_sequencer_if.slave    bus
);
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam logic [1:0] ST_TRAP = 2'd2;
`endif

  localparam logic [CNT_W-1:0]  CNT_FETCH  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_WAIT   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_EXEC   = CNT_W'(2);
  localparam logic [OPID_W-1:0] OP_HLT     = OPID_W'(6'h19);
  localparam logic [OPID_W-1:0] OP_ILLEGAL = {OPID_W{1'b1}};

  logic [1:0]        state_reg,   state_next;
  logic [CNT_W-1:0]  cnt_reg,     cnt_next;
  logic [15:0]       ir_reg,      ir_next;
  logic [OPID_W-1:0] opid_reg,    opid_next;
  logic [CNT_W-1:0]  last_reg,    last_next;
  logic              halted_reg,  halted_next;
  logic              illegal_reg, illegal_next;

  logic [OPID_W-1:0] dec_opid;
  logic [CNT_W-1:0]  dec_last;
  logic              is_hlt;
  logic              unused_ir;

  // Op index from the major opcode, low-bit function field and branch condition field.
  function automatic logic [5:0] decode_op(input logic [4:0] m, input logic [1:0] l, input logic [2:0] c);
    logic [5:0] op;
    op = 6'h3F;
    case (m)
      5'b00000: op = 6'h07 + {4'b0000, l};
      5'b00001: op = 6'h01;
      5'b00010: op = 6'h02;
      5'b00011: op = 6'h03;
      5'b00100: if (l == 2'b00) op = 6'h04;
      5'b00101: op = 6'h05;
      5'b00110: begin
        if (l == 2'b00)      op = 6'h06;
        else if (l == 2'b01) op = 6'h0B;
      end
      5'b00111: op = 6'h0C;
      5'b01000: op = 6'h0D;
      5'b01011: op = 6'h0E;
      5'b11000: begin
        case (c)
          3'b011:  op = 6'h0F;
          3'b010:  op = 6'h10;
          3'b001:  op = 6'h11;
          3'b000:  op = 6'h12;
          default: op = 6'h3F;
        endcase
      end
      5'b11001: op = 6'h13;
      5'b10000: op = 6'h14;
      5'b10001: op = 6'h15;
      5'b10010: op = 6'h16;
      5'b10011: op = 6'h17;
      5'b11100: begin
        if (l == 2'b00)      op = 6'h18;
        else if (l == 2'b01) op = 6'h19;
      end
      default:  op = 6'h3F;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] last_step(input logic [5:0] op);
    case (op)
      6'h03, 6'h04: return 3'd4;
      6'h01, 6'h02, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E, 6'h15, 6'h16: return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  assign dec_opid = OPID_W'(decode_op(bus.Ins[15:11], bus.Ins[1:0], bus.Ins[10:8]));
  assign dec_last = CNT_W'(last_step(decode_op(bus.Ins[15:11], bus.Ins[1:0], bus.Ins[10:8])));
  assign is_hlt   = (opid_reg == OP_HLT);
  // Only the opcode fields of IR leave the block; the middle bits are kept for completeness.
  assign unused_ir = ^ir_reg[10:2];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ir_next      = ir_reg;
    opid_next    = opid_reg;
    last_next    = last_reg;
    halted_next  = halted_reg;
    illegal_next = 1'b0;
    if (state_reg == ST_RUN) begin
      if (cnt_reg == CNT_FETCH) begin
        cnt_next = CNT_WAIT;
      end else if (cnt_reg == CNT_WAIT) begin
        if (bus.Ins_valid) begin
          ir_next      = bus.Ins;
          opid_next    = dec_opid;
          last_next    = dec_last;
          illegal_next = (dec_opid == OP_ILLEGAL);
          cnt_next     = CNT_EXEC;
        end
      end else if (cnt_reg >= last_reg) begin
        cnt_next = CNT_FETCH;
        if (is_hlt) begin
          state_next  = ST_HALT;
          halted_next = 1'b1;
        end
`ifdef SEQ_ILLEGAL_TRAP_EN
        else if (opid_reg == OP_ILLEGAL) begin
          state_next  = ST_TRAP;
          halted_next = 1'b1;
        end
`endif
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg   <= ST_RUN;
      cnt_reg     <= '0;
      ir_reg      <= '0;
      opid_reg    <= '0;
      last_reg    <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ir_reg      <= ir_next;
      opid_reg    <= opid_next;
      last_reg    <= last_next;
      halted_reg  <= halted_next;
      illegal_reg <= illegal_next;
    end
  end

  // HLT (and a trapping illegal op) must not advance the PC on its last step.
  assign bus.Buff_PC = (state_reg == ST_RUN) && (cnt_reg >= CNT_EXEC) && (cnt_reg == last_reg) && !is_hlt
`ifdef SEQ_ILLEGAL_TRAP_EN
                       && (opid_reg != OP_ILLEGAL)
`endif
                       ;
  assign bus.Cnt       = cnt_reg;
  assign bus.InsM      = ir_reg[15:11];
  assign bus.InsL      = ir_reg[1:0];
  assign bus.OpID      = opid_reg;
  assign bus.Halted    = halted_reg;
  assign bus.IllegalOp = illegal_reg;
endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Directed + random bench for multicycle_step_sequencer against a table-driven instruction model.
module tb_multicycle_step_sequencer;
  logic clk = 1'b0;
  logic Rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] match;
    int          op;
    int          last;
  } rule_t;
  rule_t rules[$];

  logic [4:0] exp_m;
  logic [1:0] exp_l;
  int         exp_op;

  multicycle_step_sequencer_if bus ();
  multicycle_step_sequencer dut (.clk(clk), .Rst_n(Rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [15:0] ins, output int op, output int last);
    bit found = 0;
    op = 63;
    last = 2;
    foreach (rules[i]) begin
      if (!found && ((ins & rules[i].mask) == rules[i].match)) begin
        op = rules[i].op;
        last = rules[i].last;
        found = 1;
      end
    end
  endfunction

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    chk("rst_cnt",  32'(bus.Cnt), 0);
    chk("rst_insm", 32'(bus.InsM), 0);
    chk("rst_insl", 32'(bus.InsL), 0);
    chk("rst_opid", 32'(bus.OpID), 0);
    chk("rst_bpc",  32'(bus.Buff_PC), 0);
    chk("rst_halt", 32'(bus.Halted), 0);
    chk("rst_ill",  32'(bus.IllegalOp), 0);
    exp_m = 0; exp_l = 0; exp_op = 0;
    @(negedge clk);
    Rst_n = 1'b1;
  endtask

  // Called at a negedge where a new instruction should be at step 0; returns at the
  // negedge following its last step.
  task automatic run_instr(input logic [15:0] ins, input int waits);
    int op, last;
    bit stops;
    ref_decode(ins, op, last);
    stops = (op == 25);
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (op == 63) stops = 1;
`endif
    $display("instr ins=%04h op=%02h last=%0d waits=%0d", ins, op, last, waits);
    chk("fetch_cnt", 32'(bus.Cnt), 0);
    chk("fetch_bpc", 32'(bus.Buff_PC), 0);
    chk("fetch_halt", 32'(bus.Halted), 0);
    bus.Ins_valid = 1'b0;
    @(negedge clk);
    for (int w = 0; w < waits; w++) begin
      chk("wait_cnt", 32'(bus.Cnt), 1);
      chk("wait_insm", 32'(bus.InsM), 32'(exp_m));
      chk("wait_opid", 32'(bus.OpID), 32'(exp_op));
      chk("wait_bpc", 32'(bus.Buff_PC), 0);
      bus.Ins = 16'($urandom);
      bus.Ins_valid = 1'b0;
      @(negedge clk);
    end
    chk("load_cnt", 32'(bus.Cnt), 1);
    chk("load_bpc", 32'(bus.Buff_PC), 0);
    bus.Ins = ins;
    bus.Ins_valid = 1'b1;
    @(negedge clk);
    bus.Ins_valid = 1'b0;
    bus.Ins = 16'($urandom);
    exp_m = ins[15:11];
    exp_l = ins[1:0];
    exp_op = op;
    for (int k = 2; k <= last; k++) begin
      chk("step_cnt",  32'(bus.Cnt), 32'(k));
      chk("step_opid", 32'(bus.OpID), 32'(exp_op));
      chk("step_insm", 32'(bus.InsM), 32'(exp_m));
      chk("step_insl", 32'(bus.InsL), 32'(exp_l));
      chk("step_bpc",  32'(bus.Buff_PC), 32'((k == last) && !stops));
      chk("step_ill",  32'(bus.IllegalOp), 32'((k == 2) && (op == 63)));
      chk("step_halt", 32'(bus.Halted), 0);
      @(negedge clk);
    end
  endtask

  task automatic check_stopped(input int n);
    for (int i = 0; i < n; i++) begin
      chk("stop_cnt",  32'(bus.Cnt), 0);
      chk("stop_halt", 32'(bus.Halted), 1);
      chk("stop_bpc",  32'(bus.Buff_PC), 0);
      chk("stop_ill",  32'(bus.IllegalOp), 0);
      chk("stop_opid", 32'(bus.OpID), 32'(exp_op));
      chk("stop_insm", 32'(bus.InsM), 32'(exp_m));
      bus.Ins = 16'($urandom);
      bus.Ins_valid = 1'b1;
      @(negedge clk);
    end
    bus.Ins_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] ins;
    int op, last;

    rules.push_back(rule_t'{16'hF800, 16'h0800,  1, 3});
    rules.push_back(rule_t'{16'hF800, 16'h1000,  2, 3});
    rules.push_back(rule_t'{16'hF800, 16'h1800,  3, 4});
    rules.push_back(rule_t'{16'hF803, 16'h2000,  4, 4});
    rules.push_back(rule_t'{16'hF800, 16'h2800,  5, 3});
    rules.push_back(rule_t'{16'hF803, 16'h3000,  6, 3});
    rules.push_back(rule_t'{16'hF803, 16'h0000,  7, 3});
    rules.push_back(rule_t'{16'hF803, 16'h0001,  8, 3});
    rules.push_back(rule_t'{16'hF803, 16'h0002,  9, 3});
    rules.push_back(rule_t'{16'hF803, 16'h0003, 10, 3});
    rules.push_back(rule_t'{16'hF803, 16'h3001, 11, 2});
    rules.push_back(rule_t'{16'hF800, 16'h3800, 12, 3});
    rules.push_back(rule_t'{16'hF800, 16'h4000, 13, 3});
    rules.push_back(rule_t'{16'hF800, 16'h5800, 14, 3});
    rules.push_back(rule_t'{16'hFF00, 16'hC300, 15, 2});
    rules.push_back(rule_t'{16'hFF00, 16'hC200, 16, 2});
    rules.push_back(rule_t'{16'hFF00, 16'hC100, 17, 2});
    rules.push_back(rule_t'{16'hFF00, 16'hC000, 18, 2});
    rules.push_back(rule_t'{16'hF800, 16'hC800, 19, 2});
    rules.push_back(rule_t'{16'hF800, 16'h8000, 20, 2});
    rules.push_back(rule_t'{16'hF800, 16'h8800, 21, 3});
    rules.push_back(rule_t'{16'hF800, 16'h9000, 22, 3});
    rules.push_back(rule_t'{16'hF800, 16'h9800, 23, 2});
    rules.push_back(rule_t'{16'hF803, 16'hE000, 24, 2});
    rules.push_back(rule_t'{16'hF803, 16'hE001, 25, 2});

    Rst_n = 1'b0;
    bus.Ins = 16'h0000;
    bus.Ins_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Named examples, then every legal op with random don't-care bits.
    run_instr(16'h2000, 0);
    run_instr(16'h3001, 0);
    foreach (rules[i]) begin
      if (rules[i].op <= 24) begin
        ins = rules[i].match | (16'($urandom) & ~rules[i].mask);
        run_instr(ins, 0);
      end
    end

    // Memory wait at step 1.
    run_instr(16'h0802, 3);

    // Back-to-back branch then jump-and-link.
    run_instr(16'hC100, 0);
    run_instr(16'h8800, 0);

    // Reset in the middle of LDRrr at step 3.
    chk("mid_cnt0", 32'(bus.Cnt), 0);
    bus.Ins = 16'h2000;
    bus.Ins_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.Ins_valid = 1'b0;
    @(negedge clk);
    chk("mid_cnt3", 32'(bus.Cnt), 3);
    do_reset();
    run_instr(16'h0001, 1);

    // Illegal encoding.
    run_instr(16'h6800, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
    check_stopped(10);
    do_reset();
`endif
    run_instr(16'h0000, 0);

    // Halt and recovery through reset.
    run_instr(16'hE001, 0);
    check_stopped(12);
    do_reset();

    // Random instruction stream, avoiding encodings that stop the core.
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        int idx;
        idx = $urandom_range(0, rules.size() - 1);
        ins = rules[idx].match | (ins & ~rules[idx].mask);
      end
      ref_decode(ins, op, last);
      if (op == 25) ins = 16'h0000;
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (op == 63) ins = 16'h0000;
`endif
      run_instr(ins, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
